// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// One-cycle pipeline register between two instruction-pipeline stages. It
// carries a valid bit, a halt flag, a control bundle, a destination register
// id and NCH data channels. Flush inserts a bubble and stall freezes the stage.
//
// A valid HLT instruction captured by a load moves the stage into DRAIN.
// DRAIN lasts DRAIN_CYC cycles and then the stage settles in HALT. Both DRAIN
// and HALT freeze every register, and only rst leaves HALT.
//
// The stage also counts the bubbles it produces (saturating at 16'hFFFF).
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   stall_in   in   hold all stage contents
//   flush_in   in   insert a bubble (overrides stall_in)
//   valid_in   in   upstream slot holds a real instruction
//   hlt_in     in   upstream instruction is HLT
//   ctrl_in    in   [CTRL_W]      upstream control bundle
//   wreg_in    in   [RID_W]       upstream destination register id
//   data_in    in   [NCH*DATA_W]  channel k in bits [k*DATA_W +: DATA_W]
//   valid_out  out  registered valid
//   hlt_out    out  registered halt flag
//   ctrl_out   out  [CTRL_W]      registered control, zero when valid_out=0
//   wreg_out   out  [RID_W]       registered destination id
//   data_out   out  [NCH*DATA_W]  registered data channels
//   draining   out  stage is in DRAIN
//   halted     out  stage is in HALT
//   bubble_cnt out  [16]          saturating count of bubbles produced
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 3,
  parameter int CTRL_W    = 4,
  parameter int RID_W     = 4,
  parameter int DRAIN_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    flush_in,
  input  logic                    valid_in,
  input  logic                    hlt_in,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic [RID_W-1:0]        wreg_in,
  input  logic [NCH*DATA_W-1:0]   data_in,
  output logic                    valid_out,
  output logic                    hlt_out,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic [RID_W-1:0]        wreg_out,
  output logic [NCH*DATA_W-1:0]   data_out,
  output logic                    draining,
  output logic                    halted,
  output logic [15:0]             bubble_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Drain counter preload. The counter reaches zero on the (DRAIN_CYC-1)th
  // DRAIN edge, and the next edge enters HALT. As a result, halted rises
  // exactly DRAIN_CYC cycles after hlt_out.
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYC - 1);

  state_t                  state_p1;
  logic [3:0]              cnt_p1;
  logic                    vld_p1;
  logic                    hlt_p1;
  logic [CTRL_W-1:0]       ctrl_p1;
  logic [RID_W-1:0]        wreg_p1;
  logic [NCH*DATA_W-1:0]   data_p1;
  logic                    draining_p1;
  logic                    halted_p1;
  logic [15:0]             bub_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- stage p0 -> p1 boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= RUN;
      cnt_p1      <= 4'd0;
      vld_p1      <= 1'b0;
      hlt_p1      <= 1'b0;
      ctrl_p1     <= '0;
      wreg_p1     <= '0;
      data_p1     <= '0;
      draining_p1 <= 1'b0;
      halted_p1   <= 1'b0;
      bub_p1      <= 16'd0;
    end else begin
      case (state_p1)
        RUN: begin
          if (flush_in) begin
            // Bubble: the id and data are left as they were, and only the
            // control side is cleared.
            vld_p1  <= 1'b0;
            hlt_p1  <= 1'b0;
            ctrl_p1 <= '0;
            bub_p1  <= sat_inc16(bub_p1);
          end else if (!stall_in) begin
            vld_p1  <= valid_in;
            hlt_p1  <= valid_in & hlt_in;
            ctrl_p1 <= valid_in ? ctrl_in : '0;
            wreg_p1 <= wreg_in;
            data_p1 <= data_in;
            if (!valid_in) begin
              bub_p1 <= sat_inc16(bub_p1);
            end
            // A HLT in an empty slot is not an instruction and is ignored.
            if (valid_in && hlt_in) begin
              state_p1    <= DRAIN;
              cnt_p1      <= DRAIN_LD;
              draining_p1 <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_p1 == 4'd0) begin
            state_p1    <= HALT;
            draining_p1 <= 1'b0;
            halted_p1   <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 - 4'd1;
          end
        end
        HALT: begin
          state_p1 <= HALT;
        end
        default: begin
          state_p1    <= RUN;
          cnt_p1      <= 4'd0;
          draining_p1 <= 1'b0;
          halted_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out  = vld_p1;
  assign hlt_out    = hlt_p1;
  assign ctrl_out   = ctrl_p1;
  assign wreg_out   = wreg_p1;
  assign data_out   = data_p1;
  assign draining   = draining_p1;
  assign halted     = halted_p1;
  assign bubble_cnt = bub_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Testbench for pipe_stage_reg. A behavioural model computes the expected
// outputs, and those outputs are compared on every falling edge. The halt
// sequence is modelled as the age of the captured HLT, not as an FSM. The
// bench also checks a set of hand-computed literal values on the directed
// scenarios.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
  localparam int DATA_W    = 16;
  localparam int NCH       = 3;
  localparam int CTRL_W    = 4;
  localparam int RID_W     = 4;
  localparam int DRAIN_CYC = 2;
  localparam int DW        = NCH * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_in;
  logic              flush_in;
  logic              valid_in;
  logic              hlt_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [RID_W-1:0]  wreg_in;
  logic [DW-1:0]     data_in;
  logic              valid_out;
  logic              hlt_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [RID_W-1:0]  wreg_out;
  logic [DW-1:0]     data_out;
  logic              draining;
  logic              halted;
  logic [15:0]       bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .NCH(NCH), .CTRL_W(CTRL_W), .RID_W(RID_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .hlt_in(hlt_in), .ctrl_in(ctrl_in), .wreg_in(wreg_in),
    .data_in(data_in), .valid_out(valid_out), .hlt_out(hlt_out),
    .ctrl_out(ctrl_out), .wreg_out(wreg_out), .data_out(data_out),
    .draining(draining), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. Once a HLT is captured, the stage is frozen, and the
  // model only counts how many edges have passed since the capture.
  logic              m_vld, m_hlt;
  logic [CTRL_W-1:0] m_ctrl;
  logic [RID_W-1:0]  m_wreg;
  logic [DW-1:0]     m_data;
  int                m_bub;
  bit                m_cap;
  int                m_age;
  bit                cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_vld = 0; m_hlt = 0; m_ctrl = '0; m_wreg = '0; m_data = '0;
      m_bub = 0; m_cap = 0; m_age = 0;
    end else if (m_cap) begin
      if (m_age < 1000) m_age = m_age + 1;
    end else if (flush_in) begin
      m_vld = 0; m_hlt = 0; m_ctrl = '0;
      m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
    end else if (!stall_in) begin
      m_vld  = valid_in;
      m_hlt  = valid_in && hlt_in;
      m_ctrl = valid_in ? ctrl_in : '0;
      m_wreg = wreg_in;
      m_data = data_in;
      if (!valid_in) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
      if (valid_in && hlt_in) begin
        m_cap = 1;
        m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid_out", 64'(valid_out), 64'(m_vld));
      chk("m_hlt_out",   64'(hlt_out),   64'(m_hlt));
      chk("m_ctrl_out",  64'(ctrl_out),  64'(m_ctrl));
      chk("m_wreg_out",  64'(wreg_out),  64'(m_wreg));
      chk("m_data_out",  64'(data_out),  64'(m_data));
      chk("m_bubble",    64'(bubble_cnt), 64'(m_bub));
      chk("m_draining",  64'(draining),  64'(m_cap && m_age < DRAIN_CYC));
      chk("m_halted",    64'(halted),    64'(m_cap && m_age >= DRAIN_CYC));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic [CTRL_W-1:0] c,
                       input logic [RID_W-1:0] w, input logic [DW-1:0] d,
                       input logic s, input logic f);
    valid_in = v; hlt_in = h; ctrl_in = c; wreg_in = w; data_in = d;
    stall_in = s; flush_in = f;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, '0, '0, 0, 0);
    step();
    step();
    cmp_en = 1'b1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_bub",   64'(bubble_cnt), 64'd0);
    chk("rst_data",  64'(data_out), 64'd0);
    chk("rst_drain", 64'({draining, halted}), 64'd0);
    rst = 1'b0;

    // Plain load
    drive(1, 0, 4'b0110, 4'd5, {16'h1234, 16'hABCD, 16'h0042}, 0, 0);
    step();
    chk("load_valid", 64'(valid_out), 64'd1);
    chk("load_ctrl",  64'(ctrl_out), 64'h6);
    chk("load_wreg",  64'(wreg_out), 64'd5);
    chk("load_data",  64'(data_out), 64'h1234ABCD0042);

    // Stall and flush on the same edge: flush wins and the data is kept
    drive(1, 0, 4'hF, 4'd9, 48'h111122223333, 1, 1);
    step();
    chk("sf_valid", 64'(valid_out), 64'd0);
    chk("sf_ctrl",  64'(ctrl_out), 64'd0);
    chk("sf_data",  64'(data_out), 64'h1234ABCD0042);
    chk("sf_bub",   64'(bubble_cnt), 64'd1);

    // Three stalled edges, then a load
    drive(1, 0, 4'h3, 4'd7, 48'hAAAA00000001, 0, 0);
    step();
    drive(1, 0, 4'h9, 4'd2, 48'hBBBB00000002, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", 64'(data_out), 64'hAAAA00000001);
      chk("stall_bub",  64'(bubble_cnt), 64'd1);
    end
    stall_in = 1'b0;
    step();
    chk("unstall_data", 64'(data_out), 64'hBBBB00000002);
    chk("unstall_ctrl", 64'(ctrl_out), 64'h9);

    // A HLT in an empty slot is ignored
    drive(0, 1, 4'h5, 4'd1, 48'h0, 0, 0);
    step();
    chk("ihlt_hlt",   64'(hlt_out), 64'd0);
    chk("ihlt_drain", 64'(draining), 64'd0);
    chk("ihlt_bub",   64'(bubble_cnt), 64'd2);
    chk("ihlt_ctrl",  64'(ctrl_out), 64'd0);

    // A real HLT drains and then halts
    drive(1, 1, 4'hC, 4'd3, 48'hCAFE0000BEEF, 0, 0);
    step();
    chk("hlt_hlt",    64'(hlt_out), 64'd1);
    chk("hlt_drain",  64'(draining), 64'd1);
    chk("hlt_halted", 64'(halted), 64'd0);
    drive(0, 0, 4'h1, 4'd4, 48'h0, 0, 1);
    step();
    chk("dr_valid",  64'(valid_out), 64'd1);
    chk("dr_halted", 64'(halted), 64'd0);
    step();
    chk("h_halted", 64'(halted), 64'd1);
    chk("h_drain",  64'(draining), 64'd0);
    chk("h_data",   64'(data_out), 64'hCAFE0000BEEF);
    chk("h_bub",    64'(bubble_cnt), 64'd2);
    step();
    chk("h_hold", 64'({valid_out, hlt_out, ctrl_out}), 64'h3C);

    // Bring the bubble counter to saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 65535; i++) step();
    chk("sat_full", 64'(bubble_cnt), 64'hFFFF);
    flush_in = 1'b1;
    step();
    chk("sat_stay", 64'(bubble_cnt), 64'hFFFF);

    // Reset in the middle of DRAIN
    drive(1, 1, 4'h7, 4'd6, 48'h123456789ABC, 0, 0);
    step();
    chk("mid_drain", 64'(draining), 64'd1);
    rst = 1'b1;
    stall_in = 1'b1;
    flush_in = 1'b1;
    step();
    chk("mid_rst_out", 64'({valid_out, hlt_out, ctrl_out, wreg_out}), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_st", 64'({draining, halted}), 64'd0);
    chk("mid_rst_bub", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
    drive(1, 0, 4'h2, 4'd8, 48'h00000000FFFF, 0, 0);
    step();
    chk("post_rst_load", 64'(valid_out), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst      = (($urandom % 97) == 0) || (m_cap && m_age > DRAIN_CYC + 2);
      valid_in = ($urandom % 4) != 0;
      hlt_in   = ($urandom % 20) == 0;
      stall_in = ($urandom % 5) == 0;
      flush_in = ($urandom % 7) == 0;
      ctrl_in  = CTRL_W'($urandom);
      wreg_in  = RID_W'($urandom);
      data_in  = DW'({$urandom, $urandom});
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
